// File: rtl/mpt_plb_if.sv
// Request/response, walker and flush signals of the protection lookaside buffer.
// The slave modport is the PLB's own view; master is the view of whoever drives it.
interface mpt_plb_if #(
  parameter int unsigned Xlen    = 64,
  parameter int unsigned SdidLen = 6
) ();
  logic [3:0]         mode_i;
  logic               req_valid_i;
  logic               req_ready_o;
  logic [Xlen-1:0]    req_spa_i;
  logic [SdidLen-1:0] req_sdid_i;
  logic [1:0]         req_access_i;
  logic               rsp_valid_o;
  logic               rsp_allow_o;
  logic [2:0]         rsp_err_o;
  logic               ptw_req_valid_o;
  logic               ptw_req_ready_i;
  logic [Xlen-1:0]    ptw_spa_o;
  logic [SdidLen-1:0] ptw_sdid_o;
  logic               ptw_rsp_valid_i;
  logic [2:0]         ptw_perms_i;
  logic [2:0]         ptw_err_i;
  logic               flush_i;
  logic               flush_sdid_valid_i;
  logic [SdidLen-1:0] flush_sdid_i;

  modport slave (
    input  mode_i, req_valid_i, req_spa_i, req_sdid_i, req_access_i,
           ptw_req_ready_i, ptw_rsp_valid_i, ptw_perms_i, ptw_err_i,
           flush_i, flush_sdid_valid_i, flush_sdid_i,
    output req_ready_o, rsp_valid_o, rsp_allow_o, rsp_err_o,
           ptw_req_valid_o, ptw_spa_o, ptw_sdid_o
  );

  modport master (
    output mode_i, req_valid_i, req_spa_i, req_sdid_i, req_access_i,
           ptw_req_ready_i, ptw_rsp_valid_i, ptw_perms_i, ptw_err_i,
           flush_i, flush_sdid_valid_i, flush_sdid_i,
    input  req_ready_o, rsp_valid_o, rsp_allow_o, rsp_err_o,
           ptw_req_valid_o, ptw_spa_o, ptw_sdid_o
  );
endinterface

// File: rtl/mpt_plb.sv
// Fully associative protection lookaside buffer in front of the MPT walker.
// One request in flight; misses walk once and fill from the walker's commit.
module mpt_plb #(
  parameter int unsigned NumEntries = 8,
  parameter int unsigned Xlen       = 64,
  parameter int unsigned SdidLen    = 6
) (
  input logic      clk_i,
  input logic      rst_i,
  mpt_plb_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NumEntries);
  localparam int unsigned TagW = Xlen - 12;

  localparam logic [3:0] ModeBare = 4'd0;
  localparam logic [1:0] AccNone  = 2'd0;
  localparam logic [1:0] AccRead  = 2'd1;
  localparam logic [1:0] AccWrite = 2'd2;
  localparam logic [1:0] AccExec  = 2'd3;
  localparam logic [2:0] ErrNone  = 3'd0;

  typedef enum logic [2:0] {StIdle, StLookup, StPtwReq, StPtwWait, StResp} state_e;

  state_e              state_q;
  logic [NumEntries-1:0] valid_q;
  logic [TagW-1:0]     tag_q      [NumEntries];
  logic [SdidLen-1:0]  ent_sdid_q [NumEntries];
  logic [2:0]          perm_q     [NumEntries];
  logic [IdxW-1:0]     rr_q;
  logic                drop_q;
  logic [Xlen-1:0]     spa_q;
  logic [SdidLen-1:0]  sdid_q;
  logic [1:0]          access_q;
  logic                ready_q;
  logic                rsp_valid_q;
  logic                rsp_allow_q;
  logic [2:0]          rsp_err_q;
  logic                ptw_req_valid_q;

  logic                hit_any;
  logic [2:0]          hit_perm;
  logic                any_inv;
  logic [IdxW-1:0]     victim;
  logic                bypass;

  function automatic logic perm_ok(logic [2:0] perms, logic [1:0] acc);
    case (acc)
      AccRead:  return perms[0];
      AccWrite: return perms[1];
      AccExec:  return perms[2];
      default:  return 1'b1;
    endcase
  endfunction

  assign bypass = (access_q == AccNone) || (bus.mode_i == ModeBare);

  // At most one entry can match since fills only follow misses.
  always_comb begin
    hit_any  = 1'b0;
    hit_perm = '0;
    for (int i = 0; i < NumEntries; i++) begin
      if (valid_q[i] && tag_q[i] == spa_q[Xlen-1:12] && ent_sdid_q[i] == sdid_q) begin
        hit_any  = 1'b1;
        hit_perm = hit_perm | perm_q[i];
      end
    end
  end

  always_comb begin
    victim  = rr_q;
    any_inv = 1'b0;
    for (int i = 0; i < NumEntries; i++) begin
      if (!valid_q[i] && !any_inv) begin
        victim  = IdxW'(i);
        any_inv = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      valid_q         <= '0;
      rr_q            <= '0;
      drop_q          <= 1'b0;
      spa_q           <= '0;
      sdid_q          <= '0;
      access_q        <= AccNone;
      ready_q         <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_allow_q     <= 1'b0;
      rsp_err_q       <= ErrNone;
      ptw_req_valid_q <= 1'b0;
      for (int i = 0; i < NumEntries; i++) begin
        tag_q[i]      <= '0;
        ent_sdid_q[i] <= '0;
        perm_q[i]     <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          drop_q  <= 1'b0;
          ready_q <= 1'b1;
          if (ready_q && bus.req_valid_i) begin
            ready_q  <= 1'b0;
            spa_q    <= bus.req_spa_i;
            sdid_q   <= bus.req_sdid_i;
            access_q <= bus.req_access_i;
            state_q  <= StLookup;
          end
        end
        StLookup: begin
          if (bypass || hit_any) begin
            rsp_valid_q <= 1'b1;
            rsp_allow_q <= bypass || perm_ok(hit_perm, access_q);
            rsp_err_q   <= ErrNone;
            state_q     <= StResp;
          end else begin
            ptw_req_valid_q <= 1'b1;
            state_q         <= StPtwReq;
          end
        end
        StPtwReq: begin
          if (bus.ptw_req_ready_i) begin
            ptw_req_valid_q <= 1'b0;
            state_q         <= StPtwWait;
          end
        end
        StPtwWait: begin
          if (bus.ptw_rsp_valid_i) begin
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
            if (bus.ptw_err_i == ErrNone) begin
              rsp_allow_q <= perm_ok(bus.ptw_perms_i, access_q);
              rsp_err_q   <= ErrNone;
              if (!drop_q && !bus.flush_i) begin
                valid_q[victim]    <= 1'b1;
                tag_q[victim]      <= spa_q[Xlen-1:12];
                ent_sdid_q[victim] <= sdid_q;
                perm_q[victim]     <= bus.ptw_perms_i;
                if (!any_inv) rr_q <= rr_q + 1'b1;
              end
            end else begin
              rsp_allow_q <= 1'b0;
              rsp_err_q   <= bus.ptw_err_i;
            end
          end
        end
        StResp: begin
          rsp_valid_q <= 1'b0;
          rsp_allow_q <= 1'b0;
          rsp_err_q   <= ErrNone;
          ready_q     <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Flush wins over a same-cycle fill; a walk in flight must not cache stale data.
      if (bus.flush_i) begin
        for (int i = 0; i < NumEntries; i++) begin
          if (!bus.flush_sdid_valid_i || ent_sdid_q[i] == bus.flush_sdid_i) valid_q[i] <= 1'b0;
        end
        if (state_q == StPtwReq || state_q == StPtwWait) drop_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready_o     = ready_q;
  assign bus.rsp_valid_o     = rsp_valid_q;
  assign bus.rsp_allow_o     = rsp_allow_q;
  assign bus.rsp_err_o       = rsp_err_q;
  assign bus.ptw_req_valid_o = ptw_req_valid_q;
  assign bus.ptw_spa_o       = spa_q;
  assign bus.ptw_sdid_o      = sdid_q;
endmodule
